// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath widths, issue payload and the
// opcode legality check. The optional opcode checking in alu_arb (ALU_ARB_OPCHK_EN)
// uses is_legal_op.
package alu_pkg;

   localparam int unsigned ALU_W  = 32;
   localparam int unsigned CNTL_W = 4;
   localparam int unsigned CND_W  = 2;

   typedef enum logic [CNTL_W-1:0] {
      ADD  = 4'd0,
      SLT  = 4'd1,
      SLTU = 4'd2,
      AND  = 4'd3,
      OR   = 4'd4,
      XOR  = 4'd5,
      SLL  = 4'd6,
      SRL  = 4'd7,
      SUB  = 4'd8,
      SRA  = 4'd9,
      AM   = 4'd10
   } alu_op_e;

   // Control half of an ALU request; the operands travel beside it
   typedef struct packed {
      logic [CNTL_W-1:0] cntl;
      logic              not_s;
   } op_t;

   // Encodings above AM are unused by the ALU
   function automatic logic is_legal_op(input logic [CNTL_W-1:0] op);
      return (op <= CNTL_W'(AM));
   endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Bundle of every requester, ALU and response signal around alu_arb.
// rsp_err exists only when ALU_ARB_OPCHK_EN is defined.
interface alu_arb_if
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_W
);

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [W-1:0]      req_srca_0;
   logic [W-1:0]      req_srcb_0;
   logic [CNTL_W-1:0] req_cntl_0;
   logic              req_not_s_0;
   logic [W-1:0]      req_srca_1;
   logic [W-1:0]      req_srcb_1;
   logic [CNTL_W-1:0] req_cntl_1;
   logic              req_not_s_1;

   logic [W-1:0]      alu_srca;
   logic [W-1:0]      alu_srcb;
   logic [CNTL_W-1:0] alu_cntl;
   logic              alu_not_s;
   logic [W-1:0]      alu_resalt;
   logic [CND_W-1:0]  alu_cnd;

   logic [1:0]        rsp_valid;
   logic [W-1:0]      rsp_result;
   logic [CND_W-1:0]  rsp_cnd;
`ifdef ALU_ARB_OPCHK_EN
   logic              rsp_err;
`endif

   // Arbiter side
   modport slave (
      input  req_valid,
      input  req_srca_0, req_srcb_0, req_cntl_0, req_not_s_0,
      input  req_srca_1, req_srcb_1, req_cntl_1, req_not_s_1,
      input  alu_resalt, alu_cnd,
      output req_ready,
      output alu_srca, alu_srcb, alu_cntl, alu_not_s,
`ifdef ALU_ARB_OPCHK_EN
      output rsp_err,
`endif
      output rsp_valid, rsp_result, rsp_cnd
   );

   // Requesters plus ALU side
   modport master (
      output req_valid,
      output req_srca_0, req_srcb_0, req_cntl_0, req_not_s_0,
      output req_srca_1, req_srcb_1, req_cntl_1, req_not_s_1,
      output alu_resalt, alu_cnd,
      input  req_ready,
      input  alu_srca, alu_srcb, alu_cntl, alu_not_s,
`ifdef ALU_ARB_OPCHK_EN
      input  rsp_err,
`endif
      input  rsp_valid, rsp_result, rsp_cnd
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request always wins; on contention the
// requester named by the priority pointer wins and the pointer then moves to
// the other requester. No grant is given while reset is asserted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_ptr;

   // Grant decode from requests and pointer only
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves to the requester that did not just win
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (|gnt) begin
         r_ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/alu_arb.sv
// Shares one ALU between two requesters: round-robin grant, registered issue
// stage driving the ALU, registered response stage tagged with the winner.
// Grant-to-response latency is two edges, one operation per cycle sustained.
// Optional: ALU_ARB_OPCHK_EN neutralises illegal opcodes and reports rsp_err.
module alu_arb
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_W
)(
   input  logic       clk,
   input  logic       rst_n,
   alu_arb_if.slave   bus
);

   logic [1:0]   w_gnt;
   logic         w_sel;
   logic         w_any;
   logic [W-1:0] w_srca;
   logic [W-1:0] w_srcb;
   op_t          w_op;

   logic         r_iss_v;
   logic         r_iss_id;
   logic [W-1:0] r_srca;
   logic [W-1:0] r_srcb;
   op_t          r_op;

   logic [1:0]       r_rsp_valid;
   logic [W-1:0]     r_rsp_result;
   logic [CND_W-1:0] r_rsp_cnd;

`ifdef ALU_ARB_OPCHK_EN
   logic w_legal;
   logic r_iss_err;
   logic r_rsp_err;
`endif

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bus.req_valid),
      .gnt   (w_gnt)
   );

   assign bus.req_ready = w_gnt;
   assign w_any         = |w_gnt;
   assign w_sel         = w_gnt[1];

   // Winner payload select
   always_comb begin
      w_srca = bus.req_srca_0;
      w_srcb = bus.req_srcb_0;
      w_op   = '{cntl: bus.req_cntl_0, not_s: bus.req_not_s_0};
      if (w_sel) begin
         w_srca = bus.req_srca_1;
         w_srcb = bus.req_srcb_1;
         w_op   = '{cntl: bus.req_cntl_1, not_s: bus.req_not_s_1};
      end
   end

`ifdef ALU_ARB_OPCHK_EN
   assign w_legal = is_legal_op(w_op.cntl);
`endif

   // Issue stage valid and tag follow every grant decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iss_v  <= 1'b0;
         r_iss_id <= 1'b0;
      end else begin
         r_iss_v <= w_any;
         if (w_any) begin
            r_iss_id <= w_sel;
         end
      end
   end

   // Issue operands load only on a grant so the ALU inputs stay quiet when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_srca <= '0;
         r_srcb <= '0;
         r_op   <= '{cntl: CNTL_W'(ADD), not_s: 1'b0};
`ifdef ALU_ARB_OPCHK_EN
         r_iss_err <= 1'b0;
`endif
      end else if (w_any) begin
`ifdef ALU_ARB_OPCHK_EN
         if (w_legal) begin
            r_srca    <= w_srca;
            r_srcb    <= w_srcb;
            r_op      <= w_op;
            r_iss_err <= 1'b0;
         end else begin
            // Illegal opcode becomes a harmless 0 + 0
            r_srca    <= '0;
            r_srcb    <= '0;
            r_op      <= '{cntl: CNTL_W'(ADD), not_s: w_op.not_s};
            r_iss_err <= 1'b1;
         end
`else
         r_srca <= w_srca;
         r_srcb <= w_srcb;
         r_op   <= w_op;
`endif
      end
   end

   assign bus.alu_srca  = r_srca;
   assign bus.alu_srcb  = r_srcb;
   assign bus.alu_cntl  = r_op.cntl;
   assign bus.alu_not_s = r_op.not_s;

   // Response pulse steered to the issuing requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 2'b00;
      end else begin
         r_rsp_valid <= {r_iss_v & r_iss_id, r_iss_v & ~r_iss_id};
      end
   end

   // Response data captured with each pulse and held in between
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_result <= '0;
         r_rsp_cnd    <= '0;
`ifdef ALU_ARB_OPCHK_EN
         r_rsp_err    <= 1'b0;
`endif
      end else if (r_iss_v) begin
         r_rsp_cnd <= bus.alu_cnd;
`ifdef ALU_ARB_OPCHK_EN
         r_rsp_result <= r_iss_err ? '0 : bus.alu_resalt;
         r_rsp_err    <= r_iss_err;
`else
         r_rsp_result <= bus.alu_resalt;
`endif
      end
   end

   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_cnd    = r_rsp_cnd;
`ifdef ALU_ARB_OPCHK_EN
   assign bus.rsp_err    = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed requests with hand-computed results, expected
// responses queued at each handshake and checked by an independent monitor.
// Exercises the ALU_ARB_OPCHK_EN cases when that macro is defined.
module tb_alu_arb;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic [1:0]  cnd;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb_q[$];

   logic [31:0] v_a  [2];
   logic [31:0] v_b  [2];
   logic [3:0]  v_op [2];
   logic        v_ns [2];
   logic [31:0] v_er [2];
   logic [1:0]  v_ec [2];
   logic        v_ee [2];
   int          c0;
   int          c1;

   alu_arb_if #(.W(W)) bus ();

   alu_arb #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Simple combinational ALU standing in for the core's alu instance
   always_comb begin
      bus.alu_resalt = '0;
      case (bus.alu_cntl)
         ADD:  bus.alu_resalt = bus.alu_srca + bus.alu_srcb;
         SUB:  bus.alu_resalt = bus.alu_srca - bus.alu_srcb;
         AND:  bus.alu_resalt = bus.alu_srca & bus.alu_srcb;
         OR:   bus.alu_resalt = bus.alu_srca | bus.alu_srcb;
         XOR:  bus.alu_resalt = bus.alu_srca ^ bus.alu_srcb;
         SLT:  bus.alu_resalt = {31'd0, $signed(bus.alu_srca) < $signed(bus.alu_srcb)};
         SLTU: bus.alu_resalt = {31'd0, bus.alu_srca < bus.alu_srcb};
         default: bus.alu_resalt = '0;
      endcase
      bus.alu_cnd = {((bus.alu_cntl == SLT) || (bus.alu_cntl == SLTU)) && bus.alu_resalt[0],
                     bus.alu_resalt == '0};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (bus.rsp_valid !== 2'b00) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), e.id ? 32'd2 : 32'd1);
            chk("rsp_result", bus.rsp_result, e.res);
            chk("rsp_cnd", 32'(bus.rsp_cnd), 32'(e.cnd));
            chk("rsp_latency", 32'(cyc), 32'(e.cyc));
`ifdef ALU_ARB_OPCHK_EN
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
         end
      end
   end

   task automatic present(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic ns, input logic [31:0] er,
                          input logic [1:0] ec, input logic ee);
      v_a[k] = a; v_b[k] = b; v_op[k] = op; v_ns[k] = ns;
      v_er[k] = er; v_ec[k] = ec; v_ee[k] = ee;
      if (k == 0) begin
         bus.req_srca_0 = a; bus.req_srcb_0 = b; bus.req_cntl_0 = op; bus.req_not_s_0 = ns;
      end else begin
         bus.req_srca_1 = a; bus.req_srcb_1 = b; bus.req_cntl_1 = op; bus.req_not_s_1 = ns;
      end
      bus.req_valid[k] = 1'b1;
   endtask

   task automatic chk_ready(input string name, input logic [1:0] exp);
      #1;
      chk(name, 32'(bus.req_ready), 32'(exp));
   endtask

   // One clock: record handshakes, then check the issue register and drop granted requests
   task automatic step();
      logic [1:0] g;
      g = 2'b00;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (bus.req_valid[k] && bus.req_ready[k]) begin
            exp_t e;
            g[k]  = 1'b1;
            e.id  = (k == 1);
            e.res = v_er[k];
            e.cnd = v_ec[k];
            e.err = v_ee[k];
            e.cyc = cyc + 2;
            sb_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (g[k]) begin
            bus.req_valid[k] = 1'b0;
            chk("iss_srca", bus.alu_srca, v_ee[k] ? 32'd0 : v_a[k]);
            chk("iss_srcb", bus.alu_srcb, v_ee[k] ? 32'd0 : v_b[k]);
            chk("iss_cntl", 32'(bus.alu_cntl), v_ee[k] ? 32'd0 : 32'(v_op[k]));
            chk("iss_not_s", 32'(bus.alu_not_s), 32'(v_ns[k]));
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_outstanding", 32'(sb_q.size()), 32'd0);
   endtask

   // Re-present whichever requester is idle with its next contention vector
   task automatic refill();
      if (!bus.req_valid[0]) begin
         present(0, 32'(c0), 32'd100, 4'(ADD), 1'b0, 32'(c0) + 32'd100, 2'b00, 1'b0);
         c0++;
      end
      if (!bus.req_valid[1]) begin
         present(1, 32'(c1 + 1), 32'h100, 4'(OR), 1'b0, 32'h100 | 32'(c1 + 1), 2'b00, 1'b0);
         c1++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; c0 = 0; c1 = 0;
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_srca_0 = '0; bus.req_srcb_0 = '0; bus.req_cntl_0 = '0; bus.req_not_s_0 = 1'b0;
      bus.req_srca_1 = '0; bus.req_srcb_1 = '0; bus.req_cntl_1 = '0; bus.req_not_s_1 = 1'b0;

      // Reset with both requesters presenting
      refill();
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_cnd", 32'(bus.rsp_cnd), 32'd0);
      chk("rst_alu_srca", bus.alu_srca, 32'd0);
      chk("rst_alu_srcb", bus.alu_srcb, 32'd0);
      chk("rst_alu_cntl", 32'(bus.alu_cntl), 32'd0);
      chk("rst_alu_not_s", 32'(bus.alu_not_s), 32'd0);
`ifdef ALU_ARB_OPCHK_EN
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: grants alternate starting at requester 0
      for (int i = 0; i < 6; i++) begin
         refill();
         chk_ready("contend_ready", (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end
      chk_ready("contend_tail_ready", 2'b01);
      step();
      drain();

      // Single requester 1: ADD 5 + 7
      present(1, 32'd5, 32'd7, 4'(ADD), 1'b0, 32'd12, 2'b00, 1'b0);
      chk_ready("single_ready", 2'b10);
      step();
      drain();

      // Stall: requester 1 SUB held while requester 0 wins
      present(0, 32'h0000F0F0, 32'h0000FF00, 4'(AND), 1'b0, 32'h0000F000, 2'b00, 1'b0);
      present(1, 32'd3, 32'd10, 4'(SUB), 1'b0, 32'hFFFFFFF9, 2'b00, 1'b0);
      chk_ready("stall_ready_first", 2'b01);
      step();
      chk_ready("stall_ready_held", 2'b10);
      step();
      drain();

      // Flags: signed compare and a zero result
      present(0, 32'd3, 32'd10, 4'(SLT), 1'b1, 32'd1, 2'b10, 1'b0);
      present(1, 32'h55, 32'h55, 4'(XOR), 1'b0, 32'd0, 2'b01, 1'b0);
      chk_ready("flags_ready", 2'b01);
      step();
      step();
      drain();
      chk("idle_hold_srca", bus.alu_srca, 32'h55);
      chk("idle_hold_cntl", 32'(bus.alu_cntl), 32'(XOR));

      // Mid-operation reset: the in-flight request must vanish
      present(0, 32'd1, 32'd1, 4'(ADD), 1'b0, 32'd2, 2'b00, 1'b0);
      chk_ready("midrst_ready", 2'b01);
      step();
      rst_n = 1'b0;
      sb_q.delete();
      repeat (2) begin
         @(negedge clk);
         chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("midrst_ready_low", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      present(0, 32'd20, 32'd22, 4'(ADD), 1'b0, 32'd42, 2'b00, 1'b0);
      present(1, 32'h0F, 32'hF0, 4'(OR), 1'b0, 32'hFF, 2'b00, 1'b0);
      chk_ready("midrst_ptr_zero", 2'b01);
      step();
      step();
      drain();

`ifdef ALU_ARB_OPCHK_EN
      // Illegal opcode becomes 0 with rsp_err, a following legal op clears it
      present(0, 32'd9, 32'd9, 4'b1100, 1'b0, 32'd0, 2'b01, 1'b1);
      chk_ready("opchk_ready", 2'b01);
      step();
      present(0, 32'hA5, 32'h0F, 4'(XOR), 1'b0, 32'hAA, 2'b00, 1'b0);
      step();
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
